// File: rtl/fd_event_counter_if.sv
// Signal bundle between the fd hold stage / display pins and the event counter.
// master drives the event and clear; slave is the counter itself.
interface fd_event_counter_if;
  logic        in;
  logic        clr;
  logic [15:0] count_bcd;
  logic        ovf;
  logic [3:0]  an;
  logic [7:0]  seg;

  modport master (
    output in, clr,
    input  count_bcd, ovf, an, seg
  );

  modport slave (
    input  in, clr,
    output count_bcd, ovf, an, seg
  );
endinterface

// File: rtl/fd_event_counter.sv
// Rising-edge event counter with 4-digit BCD count, sticky overflow and a
// multiplexed common-anode seven-segment scan.
module fd_event_counter #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  fd_event_counter_if.slave  bus
);
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic          in_d_reg;
  logic          rise;
  logic [15:0]   count_reg, count_next;
  logic          ovf_reg, ovf_next;
  logic [SW-1:0] scan_cnt_reg, scan_cnt_next;
  logic [1:0]    dig_reg, dig_next;
  logic [4:0]    carry;
  logic [15:0]   inc_val;
  logic [3:1]    zero_hi;
  logic [3:0]    blank;
  logic [3:0]    cur_nib;
  logic [7:0]    seg_code;

  assign rise     = bus.in & ~in_d_reg;
  assign carry[0] = 1'b1;

  // Ripple BCD increment: a nibble at 9 wraps to 0 and passes the carry up.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] nib;
      logic       nine;
      assign nib  = count_reg[4*gi +: 4];
      assign nine = (nib == 4'd9);
      assign inc_val[4*gi +: 4] = carry[gi] ? (nine ? 4'd0 : nib + 4'd1) : nib;
      assign carry[gi+1] = carry[gi] & nine;
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    ovf_next   = ovf_reg;
    if (bus.clr) begin
      count_next = 16'h0000;
      ovf_next   = 1'b0;
    end else if (rise) begin
      count_next = inc_val;
      if (carry[4]) ovf_next = 1'b1;
    end
  end

  always_comb begin
    scan_cnt_next = scan_cnt_reg + SW'(1);
    dig_next      = dig_reg;
    if (scan_cnt_reg == SCAN_LAST) begin
      scan_cnt_next = '0;
      dig_next      = dig_reg + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_d_reg     <= 1'b1;  // a level already high at reset release is not an event
      count_reg    <= 16'h0000;
      ovf_reg      <= 1'b0;
      scan_cnt_reg <= '0;
      dig_reg      <= 2'd0;
    end else begin
      in_d_reg     <= bus.in;
      count_reg    <= count_next;
      ovf_reg      <= ovf_next;
      scan_cnt_reg <= scan_cnt_next;
      dig_reg      <= dig_next;
    end
  end

  // zero_hi[k]: digit k and every digit above it are zero.
  assign zero_hi[3] = (count_reg[15:12] == 4'd0);
  generate
    for (genvar gi = 1; gi < 3; gi++) begin : g_lz
      assign zero_hi[gi] = zero_hi[gi+1] & (count_reg[4*gi +: 4] == 4'd0);
    end
  endgenerate

  assign blank   = BLANK_LZ ? {zero_hi, 1'b0} : 4'b0000;
  assign cur_nib = count_reg[4*dig_reg +: 4];

  always_comb begin
    seg_code = 8'hFF;
    if (!blank[dig_reg]) begin
      case (cur_nib)
        4'd0:    seg_code = 8'hC0;
        4'd1:    seg_code = 8'hF9;
        4'd2:    seg_code = 8'hA4;
        4'd3:    seg_code = 8'hB0;
        4'd4:    seg_code = 8'h99;
        4'd5:    seg_code = 8'h92;
        4'd6:    seg_code = 8'h82;
        4'd7:    seg_code = 8'hF8;
        4'd8:    seg_code = 8'h80;
        4'd9:    seg_code = 8'h90;
        default: seg_code = 8'hFF;
      endcase
    end
  end

  assign bus.count_bcd = count_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.an        = ~(4'b0001 << dig_reg);
  assign bus.seg       = seg_code;
endmodule

// File: tb/tb_fd_event_counter.sv
// Directed bench for fd_event_counter: expected counts are queued when an
// edge is driven and popped when the registered count should reflect it.
module tb_fd_event_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  fd_event_counter_if bus();

  fd_event_counter #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          model_cnt = 0;
  logic        model_ovf = 1'b0;
  logic [15:0] sb[$];

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One low->high event: count must be unchanged before the edge and
  // updated exactly one cycle after in rises.
  task automatic pulse(int hi, int lo);
    logic [15:0] e;
    chk("pre_edge_count", 32'(bus.count_bcd), 32'(to_bcd(model_cnt)));
    model_cnt = (model_cnt + 1) % 10000;
    if (model_cnt == 0) model_ovf = 1'b1;
    sb.push_back(to_bcd(model_cnt));
    bus.in = 1'b1;
    tick();
    e = sb.pop_front();
    chk("count", 32'(bus.count_bcd), 32'(e));
    chk("ovf", 32'(bus.ovf), 32'(model_ovf));
    repeat (hi - 1) tick();
    bus.in = 1'b0;
    repeat (lo) tick();
  endtask

  // Advance until an just switched to target, bounded.
  task automatic wait_sync(logic [3:0] target);
    logic       found;
    logic [3:0] prev;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev = bus.an;
      tick();
      if (bus.an == target && prev != target) found = 1'b1;
    end
    chk("scan_sync", 32'(found), 32'd1);
  endtask

  initial begin
    logic [3:0] an_tab [4];
    logic [7:0] seg_tab[4];
    logic [15:0] e;
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{8'h92, 8'hC0, 8'hF9, 8'hFF};
    bus.in  = 1'b1;
    bus.clr = 1'b0;

    // 1. Reset with in held high
    rst = 1'b1;
    tick();
    tick();
    chk("rst_an", 32'(bus.an), 32'h0000000E);
    chk("rst_seg", 32'(bus.seg), 32'h000000C0);
    chk("rst_count", 32'(bus.count_bcd), 32'h0);
    chk("rst_ovf", 32'(bus.ovf), 32'h0);
    rst = 1'b0;
    repeat (10) tick();
    chk("held_in_count", 32'(bus.count_bcd), 32'h0);
    chk("held_in_ovf", 32'(bus.ovf), 32'h0);
    $display("reset: count=%h ovf=%0b", bus.count_bcd, bus.ovf);
    bus.in = 1'b0;
    tick();

    // 2. Held pulses of 5, 1 and 100 cycles
    pulse(5, 3);
    pulse(1, 3);
    pulse(100, 3);
    chk("three_pulses", 32'(bus.count_bcd), 32'h0003);
    $display("held pulses: count=%h", bus.count_bcd);

    // 3. Carry chain and overflow
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    model_cnt = 0;
    model_ovf = 1'b0;
    chk("clr_count", 32'(bus.count_bcd), 32'h0);
    repeat (9999) pulse(1, 1);
    chk("count_9999", 32'(bus.count_bcd), 32'h9999);
    chk("ovf_9999", 32'(bus.ovf), 32'h0);
    $display("9999 pulses: count=%h ovf=%0b", bus.count_bcd, bus.ovf);
    pulse(1, 1);
    chk("wrap_count", 32'(bus.count_bcd), 32'h0000);
    chk("wrap_ovf", 32'(bus.ovf), 32'h1);
    $display("wrap: count=%h ovf=%0b", bus.count_bcd, bus.ovf);
    pulse(1, 1);
    chk("post_wrap_count", 32'(bus.count_bcd), 32'h0001);
    chk("post_wrap_ovf", 32'(bus.ovf), 32'h1);
    $display("post wrap: count=%h ovf=%0b", bus.count_bcd, bus.ovf);

    // 4. Clear beats a simultaneous rising edge
    repeat (41) pulse(1, 1);
    chk("count_42", 32'(bus.count_bcd), 32'h0042);
    model_cnt = 0;
    model_ovf = 1'b0;
    sb.push_back(16'h0000);
    bus.clr = 1'b1;
    bus.in  = 1'b1;
    tick();
    bus.clr = 1'b0;
    e = sb.pop_front();
    chk("clr_rise_count", 32'(bus.count_bcd), 32'(e));
    chk("clr_rise_ovf", 32'(bus.ovf), 32'h0);
    repeat (3) tick();
    chk("clr_rise_dropped", 32'(bus.count_bcd), 32'h0000);
    $display("clear priority: count=%h ovf=%0b", bus.count_bcd, bus.ovf);
    bus.in = 1'b0;
    tick();

    // 5. Scan with leading-zero blanking at 0105
    repeat (105) pulse(1, 1);
    chk("count_105", 32'(bus.count_bcd), 32'h0105);
    wait_sync(4'b1110);
    for (int i = 0; i < 16; i++) begin
      chk("scan_an", 32'(bus.an), 32'(an_tab[i / 4]));
      chk("scan_seg", 32'(bus.seg), 32'(seg_tab[i / 4]));
      $display("scan cycle %0d: an=%b seg=%h", i, bus.an, bus.seg);
      tick();
    end

    // 6. Reset on the last cycle of digit 2
    wait_sync(4'b1011);
    repeat (3) tick();
    chk("pre_rst_an", 32'(bus.an), 32'h0000000B);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_an", 32'(bus.an), 32'h0000000E);
    chk("midrst_count", 32'(bus.count_bcd), 32'h0);
    chk("midrst_ovf", 32'(bus.ovf), 32'h0);
    chk("midrst_seg", 32'(bus.seg), 32'h000000C0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dwell_an", 32'(bus.an), 32'h0000000E);
    end
    tick();
    chk("dwell_next_an", 32'(bus.an), 32'h0000000D);
    $display("reset mid-scan: an=%b count=%h", bus.an, bus.count_bcd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fd_event_counter.md
# fd_event_counter

Counts qualified events from the `fd` hold stage and shows the count on a 4-digit multiplexed seven-segment display. `fd` turns a noisy input into one clean, held-high pulse per event. This block sits directly downstream of it. It detects each rising edge of that held signal, keeps a 4-digit BCD count (0000–9999) with a sticky overflow flag, and scans the count onto common-anode display pins.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays enabled; legal range 2 to 2^20.
- `BLANK_LZ`, default 1: 1 blanks leading zeros on digits 3..1 (digit 0 is never blanked); 0 shows all digits.

Reset is synchronous and active-high.

- `clk` input, 1 bit: single system clock; all state is updated on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in` input, 1 bit: held event signal from `fd.out`, in the `clk` domain, so there is no synchronizer.
- `clr` input, 1 bit: synchronous clear of the count and of `ovf`.
- `count_bcd` output, 16 bits: registered BCD count; [15:12] is thousands, [3:0] is units.
- `ovf` output, 1 bit: sticky flag, set when the count wraps from 9999 to 0000.
- `an` output, 4 bits: active-low digit enables; `an[0]` is the units digit.
- `seg` output, 8 bits: active-low segments, bit order {dp,g,f,e,d,c,b,a}; `dp` is always 1 (off).

## Operation
**Edge detect**
- Register `in_d <= in`; `rise = in & ~in_d`.
- `in_d` resets to 1, so an input already high when reset is released is not counted.

**Counter priority**, highest first:
- `rst`: count = 0000, `ovf` = 0.
- `clr`: count = 0000, `ovf` = 0. A `rise` in the same cycle is dropped.
- `rise`: BCD increment.

**BCD increment**
- A digit at 9 becomes 0 and carries into the next digit.
- 9999 → 0000 and sets `ovf` in the same edge.
- Each nibble never holds a value above 9.

**Scan**
- Registers: `scan_cnt` counts 0..SCAN_DIV-1, and a 2-bit digit index `dig`.
- When `scan_cnt == SCAN_DIV-1`: `scan_cnt` returns to 0 and `dig` goes 0→1→2→3→0.
- The scan is not affected by `clr` or `in`. Only `rst` resets it.

**Display outputs**
- `an` = ~(1 << `dig`).
- `seg` = decode of nibble `dig` of `count_bcd`. Active-low codes:
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99
  - 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90
  - blank = FF
- Leading-zero blanking, when `BLANK_LZ` = 1: digit k (k ≥ 1) is blanked if it and every higher digit are 0.

## Timing
**Reset values**, after the `rst` edge:
- `count_bcd` = 0000, `ovf` = 0, `in_d` = 1
- `scan_cnt` = 0, `dig` = 0
- `an` = 1110, `seg` = C0

**Count latency**
- `count_bcd` updates at the first `clk` edge where `in` is sampled 1 and `in_d` is 0.
- The new value is visible one cycle after `in` rises.

**Pulse handling**
- One count per low→high transition of `in`, regardless of how long `in` stays high.
- A 1-cycle high pulse on `in` counts once.
- Back-to-back toggling 0,1,0,1 on consecutive cycles counts twice.

**Display path**
- `an` and `seg` are combinational from registered `dig` and `count_bcd`; there is no extra latency.
- A count change appears on `seg` in the same cycle `count_bcd` changes, whenever its digit is the one selected.

**Digit dwell**
- Each digit is enabled for exactly SCAN_DIV cycles.
- One full refresh takes 4·SCAN_DIV cycles.

**Reset mid-operation**
- A `rst` while `in` is high sets `in_d` = 1, so no count is taken until `in` falls and rises again.

## Test plan
All scenarios run with SCAN_DIV = 4 and BLANK_LZ = 1.

1. **Reset:** hold `rst` for 2 cycles with `in` = 1, release, keep `in` = 1 for 10 cycles → `count_bcd` = 0000, `ovf` = 0, `an` = 1110, `seg` = C0, and no increment.
2. **Held pulses:** apply 3 pulses of `in`, high for 5, 1 and 100 cycles, with 3 low cycles between → `count_bcd` = 0003; each increment lands exactly 1 cycle after the rising edge.
3. **Carry and overflow:** apply 9999 pulses → `count_bcd` = 9999, `ovf` = 0. One more pulse → 0000 with `ovf` = 1. A further pulse → 0001 with `ovf` still 1.
4. **Clear priority:** `clr` asserted in the same cycle as a rising edge at count 0042 → `count_bcd` = 0000, `ovf` = 0, and the event is not counted.
5. **Scan and blanking:** count = 0105, observe 16 cycles → `an` steps 1110→1101→1011→0111 with 4 cycles each, and `seg` shows 92, C0, F9, FF respectively.
6. **Reset mid-scan:** assert `rst` when `dig` = 2 and `scan_cnt` = 3 → the next cycle shows `an` = 1110, `count_bcd` = 0000, and the scan restarts with a full 4-cycle dwell on digit 0.
